// File: rtl/tile_store_fsm.sv
// tile_store_fsm
//   Write-back engine for the systolic array result tile. On store_start (IDLE only)
//   the M x N FP32 tile is snapshotted so the array can move on. Each of the M
//   external SRAM banks then receives columns 0..n_lim-1 at base_addr+col through
//   its own valid/ready handshake. store_done pulses once every bank has finished.
//
//   Optional build macro: TILE_STORE_RELU_EN -- zero any word whose FP32 sign bit
//   is set on the write-data path. The handshake timing does not change.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   store_start         start request, honoured only in IDLE
//   N_len               columns to write, clamped to N, sampled with start
//   base_addr           bank address of column 0, sampled with start
//   C_tile[m][n]        result tile, sampled with start
//   store_busy          high from the accepted start through the DONE cycle
//   store_done          one-cycle completion pulse
//   c_ext_we[m]         per-bank write valid
//   c_ext_addr[m]       per-bank write address
//   c_ext_wdata[m]      per-bank write data
//   c_ext_wready[m]     per-bank ready; a word is accepted when we & wready
module tile_store_fsm #(
   parameter int M  = 8,
   parameter int N  = 8,
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          store_start,
   input  logic [15:0]   N_len,
   input  logic [AW-1:0] base_addr,
   input  logic [DW-1:0] C_tile [M][N],
   output logic          store_busy,
   output logic          store_done,
   output logic [M-1:0]  c_ext_we,
   output logic [AW-1:0] c_ext_addr [M],
   output logic [DW-1:0] c_ext_wdata [M],
   input  logic [M-1:0]  c_ext_wready
);

   localparam int CW = $clog2(N + 1);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t        state, state_next;
   logic [DW-1:0] tile_buf [M][N];
   logic [CW-1:0] n_lim;
   logic [CW-1:0] start_lim;
   logic [CW-1:0] col [M];
   logic [AW-1:0] base_q;
   logic [M-1:0]  accept;
   logic [M-1:0]  fin_next;
   logic [DW-1:0] word [M];

   always_comb begin
      start_lim = (N_len > 16'(N)) ? CW'(N) : N_len[CW-1:0];
   end

   // A bank is finished after this edge if its column count (including any
   // accept happening now) has reached the limit; stalled banks hold the others
   // in WRITE without blocking their progress.
   always_comb begin
      accept   = '0;
      fin_next = '0;
      for (int unsigned m = 0; m < M; m++) begin
         accept[m]   = c_ext_we[m] & c_ext_wready[m];
         fin_next[m] = ((col[m] + CW'(accept[m])) == n_lim);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (store_start) state_next = (start_lim == '0) ? DONE : WRITE;
         WRITE:   if (&fin_next) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs depend only on registered state, so valid/addr/data stay put for
   // as long as a bank withholds ready. Addr/data are zeroed when not valid.
   always_comb begin
      store_busy = (state != IDLE);
      store_done = (state == DONE);
      c_ext_we   = '0;
      for (int unsigned m = 0; m < M; m++) begin
         word[m]        = tile_buf[m][col[m][IW-1:0]];
         c_ext_we[m]    = (state == WRITE) && (col[m] < n_lim);
         c_ext_addr[m]  = '0;
         c_ext_wdata[m] = '0;
         if (c_ext_we[m]) begin
            c_ext_addr[m] = base_q + AW'(col[m]);
`ifdef TILE_STORE_RELU_EN
            c_ext_wdata[m] = word[m][DW-1] ? '0 : word[m];
`else
            c_ext_wdata[m] = word[m];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_lim  <= '0;
         base_q <= '0;
         for (int unsigned m = 0; m < M; m++) col[m] <= '0;
      end else if (state == IDLE && store_start) begin
         n_lim  <= start_lim;
         base_q <= base_addr;
         for (int unsigned m = 0; m < M; m++) col[m] <= '0;
      end else if (state == WRITE) begin
         for (int unsigned m = 0; m < M; m++)
            if (accept[m]) col[m] <= col[m] + 1'b1;
      end
   end

   // Snapshot buffer carries no reset; it is always reloaded before use.
   always_ff @(posedge clk) begin
      if (state == IDLE && store_start) tile_buf <= C_tile;
   end

endmodule

// File: tb/tb_tile_store_fsm.sv
// tb_tile_store_fsm
//   Self-checking bench for tile_store_fsm: table of store operations, hand-written
//   reset sequences and randomized runs, all checked against a banked SRAM image
//   computed from the tile snapshot, base address and clamped column count.
module tb_tile_store_fsm;

   localparam int M  = 8;
   localparam int N  = 8;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          rst;
   logic          store_start;
   logic [15:0]   N_len;
   logic [AW-1:0] base_addr;
   logic [DW-1:0] C_tile [M][N];
   logic          store_busy;
   logic          store_done;
   logic [M-1:0]  c_ext_we;
   logic [AW-1:0] c_ext_addr [M];
   logic [DW-1:0] c_ext_wdata [M];
   logic [M-1:0]  c_ext_wready;

   tile_store_fsm #(.M(M), .N(N), .AW(AW), .DW(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .store_start  (store_start),
      .N_len        (N_len),
      .base_addr    (base_addr),
      .C_tile       (C_tile),
      .store_busy   (store_busy),
      .store_done   (store_done),
      .c_ext_we     (c_ext_we),
      .c_ext_addr   (c_ext_addr),
      .c_ext_wdata  (c_ext_wdata),
      .c_ext_wready (c_ext_wready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int            n_len;
      logic [AW-1:0] base;
      bit            rnd_ready;
      int            pat;
      bit            disturb;
      int            exp_done_k;   // -1: latency depends on random ready
   } vec_t;

   vec_t tbl [8];

   logic [DW-1:0] snap [M][N];
   logic [DW-1:0] mem [M][DEPTH];
   bit            written [M][DEPTH];
   int            acc [M];
   logic [M-1:0]  prev_stall;
   logic [AW-1:0] prev_addr [M];
   logic [DW-1:0] prev_data [M];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] w);
`ifdef TILE_STORE_RELU_EN
      return w[31] ? 32'h0 : w;
`else
      return w;
`endif
   endfunction

   task automatic fill_tile(input int pat);
      for (int m = 0; m < M; m++)
         for (int n = 0; n < N; n++) begin
            case (pat)
               0: C_tile[m][n] = 32'h3f800000 + DW'(m << 8) + DW'(n);
               2: case (n % 4)
                     0: C_tile[m][n] = 32'hBF800000;
                     1: C_tile[m][n] = 32'h80000000;
                     2: C_tile[m][n] = 32'h40000000;
                     default: C_tile[m][n] = $urandom;
                  endcase
               default: C_tile[m][n] = $urandom;
            endcase
         end
   endtask

   // One complete store; called just after a negedge with the bench idle.
   task automatic run(input int n_len, input logic [AW-1:0] base, input bit rnd_ready,
                      input bit disturb, input int exp_done_k, input string tag);
      int lim, k, done_k, done_cnt, busy_cnt;
      bit finished, all_done;
      logic [AW-1:0] a;
      lim = (n_len > N) ? N : n_len;
      for (int m = 0; m < M; m++) begin
         acc[m] = 0;
         for (int i = 0; i < DEPTH; i++) written[m][i] = 1'b0;
      end
      prev_stall = '0;
      snap = C_tile;
      N_len = 16'(n_len);
      base_addr = base;
      store_start = 1'b1;
      @(posedge clk);
      #1;
      store_start = 1'b0;
      c_ext_wready = rnd_ready ? M'($urandom) : '1;
      if (disturb)
         for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++) C_tile[m][n] = ~C_tile[m][n];
      k = 0; done_k = -1; done_cnt = 0; busy_cnt = 0; finished = 1'b0;
      while (k < 300) begin
         @(negedge clk);
         store_start = 1'b0;
         if (!store_busy) begin
            finished = 1'b1;
            break;
         end
         busy_cnt++;
         for (int m = 0; m < M; m++) begin
            if (prev_stall[m]) begin
               chk({tag, "_stall_we"}, 64'(c_ext_we[m]), 64'(1));
               chk({tag, "_stall_addr"}, 64'(c_ext_addr[m]), 64'(prev_addr[m]));
               chk({tag, "_stall_data"}, 64'(c_ext_wdata[m]), 64'(prev_data[m]));
            end
            if (c_ext_we[m] && c_ext_wready[m]) begin
               mem[m][c_ext_addr[m]] = c_ext_wdata[m];
               written[m][c_ext_addr[m]] = 1'b1;
               acc[m]++;
            end
            prev_stall[m] = c_ext_we[m] && !c_ext_wready[m];
            prev_addr[m]  = c_ext_addr[m];
            prev_data[m]  = c_ext_wdata[m];
         end
         if (store_done) begin
            done_cnt++;
            done_k = k;
            chk({tag, "_done_we"}, 64'(c_ext_we), 64'(0));
            all_done = 1'b1;
            for (int m = 0; m < M; m++) if (acc[m] != lim) all_done = 1'b0;
            chk({tag, "_done_after_all"}, 64'(all_done), 64'(1));
         end
         if (disturb && k == 2) store_start = 1'b1;
         @(posedge clk);
         #1;
         c_ext_wready = rnd_ready ? M'($urandom) : '1;
         k++;
      end
      store_start = 1'b0;
      chk({tag, "_terminated"}, 64'(finished), 64'(1));
      chk({tag, "_done_count"}, 64'(done_cnt), 64'(1));
      chk({tag, "_idle_we"}, 64'(c_ext_we), 64'(0));
      if (exp_done_k >= 0) begin
         chk({tag, "_done_latency"}, 64'(done_k), 64'(exp_done_k));
         chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_done_k + 1));
      end else begin
         chk({tag, "_done_not_early"}, 64'(done_k >= lim), 64'(1));
      end
      for (int m = 0; m < M; m++) begin
         chk({tag, "_accepts"}, 64'(acc[m]), 64'(lim));
         for (int c = 0; c < lim; c++) begin
            a = base + AW'(c);
            chk({tag, "_mem"}, {31'(0), written[m][a], mem[m][a]},
                {31'(0), 1'b1, ref_word(snap[m][c])});
         end
      end
   endtask

   initial begin
      tbl[0] = '{8,  10'h000, 1'b0, 0, 1'b0, 8};
      tbl[1] = '{5,  10'h003, 1'b1, 1, 1'b0, -1};
      tbl[2] = '{4,  10'h3FE, 1'b0, 1, 1'b0, 4};
      tbl[3] = '{0,  10'h005, 1'b0, 1, 1'b0, 0};
      tbl[4] = '{20, 10'h007, 1'b0, 1, 1'b0, 8};
      tbl[5] = '{8,  10'h100, 1'b0, 0, 1'b1, 8};
      tbl[6] = '{3,  10'h3FF, 1'b0, 2, 1'b0, 3};
      tbl[7] = '{8,  10'h3F0, 1'b1, 2, 1'b1, -1};

      rst = 1'b1;
      store_start = 1'b0;
      N_len = '0;
      base_addr = '0;
      c_ext_wready = '1;
      for (int m = 0; m < M; m++)
         for (int n = 0; n < N; n++) C_tile[m][n] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(store_busy), 64'(0));
      chk("rst_done", 64'(store_done), 64'(0));
      chk("rst_we", 64'(c_ext_we), 64'(0));
      for (int m = 0; m < M; m++) begin
         chk("rst_addr", 64'(c_ext_addr[m]), 64'(0));
         chk("rst_wdata", 64'(c_ext_wdata[m]), 64'(0));
      end
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         fill_tile(tbl[i].pat);
         run(tbl[i].n_len, tbl[i].base, tbl[i].rnd_ready, tbl[i].disturb,
             tbl[i].exp_done_k, $sformatf("vec%0d", i));
      end

      // Reset in the middle of WRITE aborts with no completion pulse.
      fill_tile(0);
      N_len = 16'd8;
      base_addr = 10'h020;
      store_start = 1'b1;
      @(posedge clk);
      #1;
      store_start = 1'b0;
      c_ext_wready = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_busy", 64'(store_busy), 64'(1));
      chk("pre_rst_we", 64'(c_ext_we), 64'(8'hFF));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_we", 64'(c_ext_we), 64'(0));
      chk("mid_rst_busy", 64'(store_busy), 64'(0));
      chk("mid_rst_done", 64'(store_done), 64'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_done", 64'(store_done), 64'(0));
      chk("post_rst_busy", 64'(store_busy), 64'(0));
      fill_tile(1);
      run(6, 10'h200, 1'b0, 1'b0, 6, "after_rst");

      for (int i = 0; i < 6; i++) begin
         fill_tile(1);
         run(int'($urandom_range(0, 12)), AW'($urandom), 1'b1, 1'b0, -1,
             $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
